pipe_stage_skid: RTL and testbench

Generic parametrised pipeline-stage register for the 5-stage CPU. It replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block.
- Carries a control bundle and a data bundle with valid/ready flow control.
- Supports stall (hold) and flush (squash to NOP).
- Has an optional 2-entry skid buffer, so the upstream ready path is registered.
- Includes saturating stall and flush event counters for performance debug.

---
 rtl/pipe_pkg.sv | 82 ++++++++
 rtl/pipe_stage_skid_sat_counter.sv | 25 ++
 rtl/pipe_stage_skid.sv | 110 +++++++++++
 tb/tb_pipe_stage_skid.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions for the 5-stage CPU.
// Per-stage control/data bundle layouts, their widths, and the all-zero NOP
// control constant used when a stage is squashed or holds a bubble.
package pipe_pkg;

  // IF/ID
  typedef struct packed {
    logic pred_taken;
  } ifid_ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_data_t;

  // ID/EX
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [3:0] alu_op;
  } idex_ctrl_t;

  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [6:0]  opcode;
  } idex_data_t;

  // EX/MEM
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic [2:0] funct3;
  } exmem_ctrl_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
  } exmem_data_t;

  // MEM/WB
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } memwb_ctrl_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] mem_data;
    logic [4:0]  rd;
  } memwb_data_t;

  localparam int IFID_CTRL_W  = $bits(ifid_ctrl_t);
  localparam int IFID_DATA_W  = $bits(ifid_data_t);
  localparam int IDEX_CTRL_W  = $bits(idex_ctrl_t);
  localparam int IDEX_DATA_W  = $bits(idex_data_t);
  localparam int EXMEM_CTRL_W = $bits(exmem_ctrl_t);
  localparam int EXMEM_DATA_W = $bits(exmem_data_t);
  localparam int MEMWB_CTRL_W = $bits(memwb_ctrl_t);
  localparam int MEMWB_DATA_W = $bits(memwb_data_t);

  localparam ifid_ctrl_t  IFID_CTRL_NOP  = '0;
  localparam idex_ctrl_t  IDEX_CTRL_NOP  = '0;
  localparam exmem_ctrl_t EXMEM_CTRL_NOP = '0;
  localparam memwb_ctrl_t MEMWB_CTRL_NOP = '0;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating event counter.
// Ports: clk, rst_n (async, active-low), clr (sync clear), inc (count enable),
// cnt (current value, sticks at all-ones).
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= sat_inc(cnt);
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline-stage register with valid/ready flow control, stall,
// flush, optional 2-entry skid buffer and saturating stall/flush counters.
// Ports: clk, rst_n; flush, stall; in_valid/in_ready/in_ctrl/in_data
// (upstream); out_valid/out_ready/out_ctrl/out_data (downstream);
// stall_cnt, flush_cnt (performance debug).
// Entry naming: *_p1 is the main entry driving the outputs, *_p0 the skid entry.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = IDEX_CTRL_W,
  parameter int DATA_W   = IDEX_DATA_W,
  parameter bit SKID     = 1'b1,
  parameter bit CLR_DATA = 1'b0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              vld_p0, vld_p1;
  logic              rdy_p0;
  logic [CTRL_W-1:0] ctrl_p0, ctrl_p1;
  logic [DATA_W-1:0] data_p0, data_p1;
  logic              acc, take;

  assign take     = vld_p1 & out_ready & ~stall;
  // With the skid entry, in_ready comes straight from a flop (skid empty).
  assign in_ready = SKID ? rdy_p0 : (~vld_p1 | (out_ready & ~stall));
  assign acc      = in_valid & in_ready;

  // Stage boundary: input beat -> skid entry (p0) / main entry (p1)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      rdy_p0  <= 1'b1;
      ctrl_p0 <= '0;
      ctrl_p1 <= '0;
      data_p0 <= '0;
      data_p1 <= '0;
    end else if (flush) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      rdy_p0  <= 1'b1;
      ctrl_p0 <= '0;
      ctrl_p1 <= '0;
      if (CLR_DATA) begin
        data_p0 <= '0;
        data_p1 <= '0;
      end
    end else if (vld_p0) begin
      // Skid occupied: upstream is blocked, so only a hand-off can happen.
      if (take) begin
        vld_p0  <= 1'b0;
        rdy_p0  <= 1'b1;
        ctrl_p1 <= ctrl_p0;
        data_p1 <= data_p0;
        ctrl_p0 <= '0;
      end
    end else if (acc) begin
      if (!vld_p1 || take) begin
        vld_p1  <= 1'b1;
        ctrl_p1 <= in_ctrl;
        data_p1 <= in_data;
      end else if (SKID) begin
        vld_p0  <= 1'b1;
        rdy_p0  <= 1'b0;
        ctrl_p0 <= in_ctrl;
        data_p0 <= in_data;
      end
    end else if (take) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
    end
  end

  // Stage boundary: main entry -> downstream
  assign out_valid = vld_p1;
  assign out_ctrl  = vld_p1 ? ctrl_p1 : '0;
  assign out_data  = data_p1;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (stall & vld_p1),
    .cnt   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (flush & (vld_p1 | vld_p0)),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush, stall, in_valid, out_ready;
  logic [10:0]  in_ctrl;
  logic [159:0] in_data;

  logic         in_ready, out_valid;
  logic [10:0]  out_ctrl;
  logic [159:0] out_data;
  logic [15:0]  stall_cnt, flush_cnt;

  logic         s_in_ready, s_out_valid;
  logic [10:0]  s_out_ctrl;
  logic [159:0] s_out_data;
  logic [1:0]   s_stall_cnt, s_flush_cnt;

  logic         z_in_ready, z_out_valid;
  logic [10:0]  z_out_ctrl;
  logic [159:0] z_out_data;
  logic [15:0]  z_stall_cnt, z_flush_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipe_stage_skid dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_stage_skid #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  pipe_stage_skid #(.SKID(1'b0), .CLR_DATA(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(z_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(z_out_valid), .out_ready(out_ready), .out_ctrl(z_out_ctrl), .out_data(z_out_data),
    .stall_cnt(z_stall_cnt), .flush_cnt(z_flush_cnt)
  );

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; in_ctrl = 11'h5A5; in_data = '0;
    tick();
    // reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ctrl",  out_ctrl, 0);
    chk("rst_out_data",  out_data, 0);
    chk("rst_in_ready",  in_ready, 1);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    tick();
    rst_n = 1'b1;

    // 1: streaming, 1-cycle latency
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 160'(i);
      tick();
      chk("stream_valid", out_valid, 1);
      chk("stream_data",  out_data, 160'(i));
      chk("stream_ctrl",  out_ctrl, 11'h5A5);
      chk("stream_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", out_valid, 0);
    chk("drain_ctrl",  out_ctrl, 0);

    // 2: backpressure into the skid entry
    out_ready = 1'b0; in_valid = 1'b1; in_data = 160'd11;
    tick();
    chk("bp_m_data",  out_data, 11);
    chk("bp_m_ready", in_ready, 1);
    in_data = 160'd12;
    tick();
    chk("bp_s_data",  out_data, 11);
    chk("bp_s_ready", in_ready, 0);
    in_data = 160'd13;
    tick();
    chk("bp_hold_data",  out_data, 11);
    chk("bp_hold_ready", in_ready, 0);
    chk("bp_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    chk("bp_rel_data",  out_data, 12);
    chk("bp_rel_ready", in_ready, 1);
    tick();
    chk("bp_rel2_data", out_data, 13);
    in_valid = 1'b0;
    tick();
    chk("bp_end_valid", out_valid, 0);

    // 3: stall freezes the main entry
    in_valid = 1'b1; in_data = 160'd21;
    tick();
    chk("st_load", out_data, 21);
    in_valid = 1'b0; stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("st_frozen_data",  out_data, 21);
      chk("st_frozen_valid", out_valid, 1);
      chk("st_cnt", stall_cnt, 16'(i));
    end
    stall = 1'b0;
    tick();
    chk("st_release_valid", out_valid, 0);
    chk("st_release_cnt",   stall_cnt, 4);
    stall = 1'b1;
    tick();
    chk("st_empty_cnt", stall_cnt, 4);
    stall = 1'b0;

    // 4: flush while BUSY drops all entries and the offered beat
    out_ready = 1'b0; in_valid = 1'b1; in_data = 160'd31;
    tick();
    in_data = 160'd32;
    tick();
    chk("fl_busy_ready", in_ready, 0);
    flush = 1'b1; in_data = 160'd33;
    tick();
    chk("fl_valid",  out_valid, 0);
    chk("fl_ctrl",   out_ctrl, 0);
    chk("fl_ready",  in_ready, 1);
    chk("fl_cnt",    flush_cnt, 1);
    chk("fl_stale",  out_data, 31);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("fl_after_valid", out_valid, 0);
    flush = 1'b1; in_valid = 1'b1; in_data = 160'd34;
    tick();
    chk("fl_empty_valid", out_valid, 0);
    chk("fl_empty_cnt",   flush_cnt, 1);
    flush = 1'b0; in_valid = 1'b0;

    // 6: async reset mid-stream while BUSY
    out_ready = 1'b0; in_valid = 1'b1; in_data = 160'd41;
    tick();
    in_data = 160'd42;
    tick();
    in_valid = 1'b0;
    chk("ar_busy", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid",     out_valid, 0);
    chk("ar_data",      out_data, 0);
    chk("ar_ready",     in_ready, 1);
    chk("ar_stall_cnt", stall_cnt, 0);
    chk("ar_flush_cnt", flush_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_post_valid", out_valid, 0);
    chk("ar_post_ready", in_ready, 1);

    // 5: saturation of a 2-bit counter
    out_ready = 1'b1; in_valid = 1'b1; in_data = 160'd51;
    tick();
    in_valid = 1'b0; stall = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("sat_cnt", s_stall_cnt, (i < 3) ? 160'(i) : 160'd3);
    end
    chk("sat_wide_cnt", stall_cnt, 6);
    stall = 1'b0;

    // SKID=0 / CLR_DATA=1 variant
    do_reset();
    out_ready = 1'b0; in_valid = 1'b0;
    #1;
    chk("z_empty_ready", z_in_ready, 1);
    in_valid = 1'b1; in_data = 160'd61;
    tick();
    chk("z_load_valid", z_out_valid, 1);
    chk("z_load_data",  z_out_data, 61);
    chk("z_full_ready", z_in_ready, 0);
    out_ready = 1'b1;
    #1;
    chk("z_comb_ready", z_in_ready, 1);
    stall = 1'b1;
    #1;
    chk("z_stall_ready", z_in_ready, 0);
    stall = 1'b0; in_data = 160'd62;
    tick();
    chk("z_pass_data", z_out_data, 62);
    flush = 1'b1; in_data = 160'd63;
    tick();
    chk("z_fl_valid", z_out_valid, 0);
    chk("z_fl_data",  z_out_data, 0);
    chk("z_fl_ctrl",  z_out_ctrl, 0);
    chk("z_fl_cnt",   z_flush_cnt, 1);
    flush = 1'b0; in_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
